wb_host_initiator: RTL and testbench
====================================

WB_HOST_INITIATOR -- requirements
Module: wb_host_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, range 1..255: BUS-state cycles allowed without ack before abort.
REQ-002 wb_clk_i  input  1  sole clock; all logic on rising edge.
REQ-003 wb_rst_i  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid_i  input  1  command request.
REQ-005 cmd_ready_o  output  1  command accepted when high with cmd_valid_i.
REQ-006 cmd_we_i  input  1  1 = write, 0 = read.
REQ-007 cmd_adr_i  input  32  byte address.
REQ-008 cmd_dat_i  input  32  write data.
REQ-009 cmd_sel_i  input  4  byte lane selects.
REQ-010 rsp_valid_o  output  1  response available.
REQ-011 rsp_ready_i  input  1  response consumed when high with rsp_valid_o.
REQ-012 rsp_dat_o  output  32  read data; 0 for writes and errors.
REQ-013 rsp_err_o  output  1  1 = transaction timed out.
REQ-014 busy_o  output  1  high in any state other than IDLE.
REQ-015 wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone classic master controls.
REQ-016 wbm_adr_o  output  32; wbm_dat_o  output  32; wbm_sel_o  output  4  Wishbone address, write data, selects.
REQ-017 wbm_dat_i  input  32; wbm_ack_i  input  1  Wishbone read data, acknowledge.

Function
REQ-018 FSM states IDLE, BUS, RESP; all outputs registered except cmd_ready_o, which is high exactly in IDLE.
REQ-019 IDLE: on cmd_valid_i && cmd_ready_o at edge N, latch we/adr/dat/sel onto wbm_* outputs and enter BUS; wbm_cyc_o = wbm_stb_o = 1 from cycle N+1.
REQ-020 BUS: wbm_cyc_o and wbm_stb_o held high; wbm_adr_o/dat_o/sel_o/we_o held stable for the whole cycle.
REQ-021 BUS, wbm_ack_i sampled high at edge K: cyc/stb low from K+1; rsp_valid_o = 1 and rsp_err_o = 0 from K+1; rsp_dat_o = wbm_dat_i for reads, 0 for writes; enter RESP.
REQ-022 Minimum command-accept-to-response latency 2 cycles (ack in first BUS cycle).
REQ-023 8-bit timeout counter cleared on BUS entry, incremented each BUS cycle without ack; when the count reaches TIMEOUT_CYCLES: cyc/stb low next cycle, rsp_valid_o = 1, rsp_err_o = 1, rsp_dat_o = 0, enter RESP.
REQ-024 Ack in the same cycle as timeout expiry: ack wins, normal response, rsp_err_o = 0.
REQ-025 RESP: rsp_valid_o, rsp_dat_o, rsp_err_o held until rsp_ready_i sampled high; then rsp_valid_o low next cycle and return to IDLE; no new command accepted in that cycle.
REQ-026 wbm_ack_i in IDLE or RESP ignored; no state or output change.
REQ-027 Only one transaction outstanding; cmd_valid_i outside IDLE has no effect.
REQ-028 wbm_* address/data/sel/we hold last latched values after the cycle ends; not cleared.

Reset
REQ-029 wb_rst_i sampled high at any edge, including mid-BUS or mid-RESP: next cycle state IDLE, all outputs 0 (wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, rsp_valid_o, rsp_dat_o, rsp_err_o, busy_o), timeout counter 0, cmd_ready_o 1.
REQ-030 A transaction interrupted by reset produces no response.

Verification
REQ-031 Write 0xA5A5_0001 to 0x3000_0004, sel 0xF, ack 2 cycles after stb -> wbm_* stable through ack; rsp_valid_o next cycle, rsp_dat_o 0, rsp_err_o 0.
REQ-032 Read 0x3000_0000, slave acks first cycle with 0x1234_5678 -> rsp_valid_o 2 cycles after command accept, rsp_dat_o 0x1234_5678.
REQ-033 TIMEOUT_CYCLES=4, no ack -> cyc/stb high exactly 4 cycles, then rsp_err_o 1, rsp_dat_o 0; repeat with ack on cycle 4 -> rsp_err_o 0.
REQ-034 rsp_ready_i low 5 cycles after response -> rsp_valid_o/dat/err stable, cmd_ready_o 0, new cmd_valid_i ignored; ready high -> IDLE next cycle.
REQ-035 Reset asserted mid-BUS -> cyc/stb 0 next cycle, no rsp_valid_o; following read completes normally.
REQ-036 Spurious wbm_ack_i pulses in IDLE and RESP -> no output change.

Source files
------------

// File: rtl/wb_host_initiator.sv
// Single-outstanding Wishbone classic master: turns a valid/ready command into
// one bus cycle and returns a registered response, aborting on ack timeout.
module wb_host_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam int unsigned CNT_W = 8;
    // Abort decision is taken on the edge that ends the last allowed BUS cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cyc_q, cyc_d;
    logic               we_q, we_d;
    logic [31:0]        adr_q, adr_d;
    logic [31:0]        dat_q, dat_d;
    logic [3:0]         sel_q, sel_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_dat_q, rsp_dat_d;
    logic               rsp_err_q, rsp_err_d;
    logic               busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        busy_d      = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    state_d = ST_BUS;
                    cnt_d   = '0;
                    cyc_d   = 1'b1;
                    we_d    = cmd_we_i;
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                    sel_d   = cmd_sel_i;
                    busy_d  = 1'b1;
                end
            end
            ST_BUS: begin
                // Ack takes priority over a timeout expiring in the same cycle.
                if (wbm_ack_i) begin
                    state_d     = ST_RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = we_q ? 32'h0 : wbm_dat_i;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = 32'h0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = busy_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_sel_o   = sel_q;

endmodule

// File: tb/tb_wb_host_initiator.sv
// Directed bench for wb_host_initiator with a 4-cycle timeout.
module tb_wb_host_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        busy;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [31:0] rdat;
    logic        ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_host_initiator #(.TIMEOUT_CYCLES(4)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .busy_o      (busy),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (we),
        .wbm_adr_o   (adr),
        .wbm_dat_o   (wdat),
        .wbm_sel_o   (sel),
        .wbm_dat_i   (rdat),
        .wbm_ack_i   (ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_we    = w;
        cmd_adr   = a;
        cmd_dat   = d;
        cmd_sel   = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("consume_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("consume_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("consume_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        cmd_sel = '0; rsp_ready = 1'b0; rdat = '0; ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_cyc", 32'(cyc), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_adr", adr, 32'h0);

        // Write acked on the third stb cycle
        issue(1'b1, 32'h3000_0004, 32'hA5A5_0001, 4'hF);
        rdat = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) ack = 1'b1;
            chk("wr_cyc", 32'(cyc), 32'd1);
            chk("wr_stb", 32'(stb), 32'd1);
            chk("wr_we", 32'(we), 32'd1);
            chk("wr_adr", adr, 32'h3000_0004);
            chk("wr_dat", wdat, 32'hA5A5_0001);
            chk("wr_sel", 32'(sel), 32'hF);
            chk("wr_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("wr_rsp_valid_early", 32'(rsp_valid), 32'd0);
            tick();
        end
        ack = 1'b0;
        chk("wr_cyc_done", 32'(cyc), 32'd0);
        chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr_rsp_dat", rsp_dat, 32'h0);
        chk("wr_rsp_err", 32'(rsp_err), 32'd0);
        chk("wr_adr_held", adr, 32'h3000_0004);
        consume();

        // Read acked in first BUS cycle, then response held under backpressure
        issue(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        rdat = 32'h1234_5678;
        ack  = 1'b1;
        chk("rd_cyc", 32'(cyc), 32'd1);
        chk("rd_we", 32'(we), 32'd0);
        chk("rd_rsp_valid_early", 32'(rsp_valid), 32'd0);
        tick();
        chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rd_rsp_dat", rsp_dat, 32'h1234_5678);
        chk("rd_rsp_err", 32'(rsp_err), 32'd0);
        chk("rd_cyc_done", 32'(cyc), 32'd0);
        rdat = 32'h5555_AAAA;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h7000_0000;
        for (int i = 0; i < 5; i++) begin
            ack = (i % 2 == 0);
            tick();
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_dat", rsp_dat, 32'h1234_5678);
            chk("bp_rsp_err", 32'(rsp_err), 32'd0);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_cyc", 32'(cyc), 32'd0);
            chk("bp_adr", adr, 32'h3000_0000);
        end
        cmd_valid = 1'b0; ack = 1'b0;
        consume();

        // Spurious acks while idle
        ack = 1'b1;
        tick(); tick();
        ack = 1'b0;
        chk("idle_ack_cyc", 32'(cyc), 32'd0);
        chk("idle_ack_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_ack_busy", 32'(busy), 32'd0);
        chk("idle_ack_adr", adr, 32'h3000_0000);

        // Timeout with no ack: stb high exactly four cycles
        issue(1'b0, 32'h0000_0040, 32'h0, 4'h3);
        rdat = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            chk("to_cyc", 32'(cyc), 32'd1);
            chk("to_rsp_valid_early", 32'(rsp_valid), 32'd0);
            tick();
        end
        chk("to_cyc_done", 32'(cyc), 32'd0);
        chk("to_stb_done", 32'(stb), 32'd0);
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_rsp_err", 32'(rsp_err), 32'd1);
        chk("to_rsp_dat", rsp_dat, 32'h0);
        consume();

        // Ack coinciding with timeout expiry wins
        issue(1'b0, 32'h0000_0044, 32'h0, 4'hF);
        rdat = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) ack = 1'b1;
            chk("toack_cyc", 32'(cyc), 32'd1);
            tick();
        end
        ack = 1'b0;
        chk("toack_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("toack_rsp_err", 32'(rsp_err), 32'd0);
        chk("toack_rsp_dat", rsp_dat, 32'hCAFE_F00D);
        consume();

        // Reset in the middle of a BUS cycle
        issue(1'b1, 32'h5000_0010, 32'h0F0F_0F0F, 4'hC);
        chk("mid_cyc", 32'(cyc), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_cyc", 32'(cyc), 32'd0);
        chk("mrst_stb", 32'(stb), 32'd0);
        chk("mrst_we", 32'(we), 32'd0);
        chk("mrst_adr", adr, 32'h0);
        chk("mrst_dat", wdat, 32'h0);
        chk("mrst_sel", 32'(sel), 32'h0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mrst_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Follow-up read after reset
        issue(1'b0, 32'h3000_0008, 32'h0, 4'hF);
        rdat = 32'h0BAD_CAFE;
        ack  = 1'b1;
        tick();
        ack  = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("post_rsp_dat", rsp_dat, 32'h0BAD_CAFE);
        chk("post_rsp_err", 32'(rsp_err), 32'd0);
        consume();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
